seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning maximum pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection and 0 = non-overlapping detection.
REQ-003 SHALL have parameter MEALY, default 0, meaning 1 = combinational (Mealy) match output and 0 = registered (Moore) match output.
REQ-004 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port x, input, 1 bit: serial data bit.
REQ-008 SHALL have port x_valid, input, 1 bit: x is sampled only on edges where this is 1.
REQ-009 SHALL have port cfg_load, input, 1 bit: load strobe for pattern and length.
REQ-010 SHALL have port cfg_pattern, input, PAT_W bits: pattern, LSB = most recent (last-arriving) bit.
REQ-011 SHALL have port cfg_len, input, $clog2(PAT_W+1) bits: active pattern length L.
REQ-012 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the match counter.
REQ-013 SHALL have port z, output, 1 bit: match indication.
REQ-014 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-015 SHALL have port cfg_err, output, 1 bit: sticky flag for an illegal cfg_len.

Function
REQ-016 SHALL hold a history shift register hist[PAT_W-1:0] and a fill counter fill (0..PAT_W); on an accepted bit, hist = {hist[PAT_W-2:0], x} and fill increments, saturating at PAT_W.
REQ-017 SHALL define "hit" for an accepted bit as: (fill_next >= L) and the low L bits of the post-shift history equal the low L bits of the stored pattern.
REQ-018 SHALL, when OVERLAP=1, keep the history unchanged after a hit (1011 in stream 1011011 gives two hits).
REQ-019 SHALL, when OVERLAP=0, set fill to 0 on the edge that accepts a hitting bit, so the bits of a match are never reused.
REQ-020 SHALL, when MEALY=1, drive z = hit combinationally from the current x, x_valid, hist, fill and configuration; z is 0 whenever x_valid = 0.
REQ-021 SHALL, when MEALY=0, drive z from a flop: z = 1 for exactly the one cycle following the edge that accepted a hitting bit, otherwise 0.
REQ-022 SHALL increment match_cnt by 1 on each edge that accepts a hitting bit; it saturates at 2^CNT_W-1 and never wraps.
REQ-023 SHALL, on cnt_clr=1, clear match_cnt to 0; when cnt_clr and a hit coincide, the clear wins and the result is 0.
REQ-024 SHALL, on cfg_load=1, capture cfg_pattern and cfg_len and clear fill and hist to 0.
REQ-025 SHALL ignore x during a cfg_load edge, and that edge shall produce no hit and no z.
REQ-026 SHALL hold the registered z at 0 in the cycle following a cfg_load edge.
REQ-027 SHALL treat cfg_len = 0 or cfg_len > PAT_W as illegal: the load of pattern and length is still applied, but L is clamped to PAT_W and cfg_err is set to 1.
REQ-028 SHALL clear cfg_err only on reset.
REQ-029 SHALL leave all state unchanged on edges with x_valid = 0, except cnt_clr and cfg_load.
REQ-030 SHALL ignore pattern bits above L in hit comparison.
REQ-031 SHALL derive the detection latency from REQ-020 and REQ-021: MEALY=1 gives z in the same cycle the last bit is presented; MEALY=0 gives z one cycle later.

Reset
REQ-032 SHALL, while reset=1, asynchronously force: hist=0, fill=0, registered z=0, match_cnt=0, cfg_err=0, stored pattern = {PAT_W{1'b0}} with its low 4 bits = 4'b1011 (when PAT_W >= 4), and L = min(4, PAT_W).
REQ-033 SHALL drive a Mealy z of 0 while reset=1.
REQ-034 SHALL release reset with no hit possible until L new bits have been accepted; a reset asserted mid-stream discards all partial history.

Verification
REQ-035 SHALL cover: PAT_W=4, OVERLAP=1, MEALY=0, default pattern; x = 1,0,1,1,0,1,1 on consecutive valid cycles -> z pulses one cycle after the 4th and 7th bits, match_cnt = 2.
REQ-036 SHALL cover: the same stream with OVERLAP=0 -> a single z pulse after the 4th bit, match_cnt = 1.
REQ-037 SHALL cover: MEALY=1 with the same stream and x_valid toggling 1,0 between bits -> z is high only during the valid cycles carrying the 4th and 7th bits, and is never high while x_valid = 0.
REQ-038 SHALL cover: cfg_load of pattern 3'b110 with L=3 after bits 1,1 -> the history is cleared; the following 1,1,0 give a hit on the 0; the preceding partial bits do not contribute.
REQ-039 SHALL cover: CNT_W=2 with 5 hits -> match_cnt saturates at 3; cnt_clr coincident with a 6th hit -> match_cnt = 0.
REQ-040 SHALL cover: cfg_len = 0 -> cfg_err = 1 and L = PAT_W; then reset asserted asynchronously mid-stream -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a runtime-loadable pattern and length.
//
// The history holds the most recent bits, with the LSB being the newest one. A hit is
// flagged when the low L bits of the history after the shift equal the low L bits of
// the stored pattern, and at least L bits have been accepted since the last
// reset/load. With OVERLAP=0 the bits that made up a match are not reused.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : asynchronous, active-high
//   x, x_valid  : serial data bit and its qualifier
//   cfg_load    : load strobe for cfg_pattern / cfg_len (also clears history)
//   cfg_pattern : PAT_W-bit pattern, LSB = last-arriving bit
//   cfg_len     : active pattern length L (0 or > PAT_W is illegal -> clamped)
//   cnt_clr     : synchronous clear of match_cnt (wins over a coincident hit)
//   z           : match indication (combinational if MEALY=1, registered pulse otherwise)
//   match_cnt   : saturating match counter
//   cfg_err     : sticky illegal-length flag, cleared only by reset
module seq_detect_param #(
   parameter int PAT_W   = 4,
   parameter int OVERLAP = 1,
   parameter int MEALY   = 0,
   parameter int CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       x,
   input  logic                       x_valid,
   input  logic                       cfg_load,
   input  logic [PAT_W-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
   input  logic                       cnt_clr,
   output logic                       z,
   output logic [CNT_W-1:0]           match_cnt,
   output logic                       cfg_err
);

   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] LEN_RST = LEN_W'((PAT_W < 4) ? PAT_W : 4);

   // Reset pattern is 4'b1011 truncated or zero-extended to PAT_W.
   function automatic logic [PAT_W-1:0] pat_rst_val();
      logic [3:0]       base;
      logic [PAT_W-1:0] p;
      base = 4'b1011;
      p    = '0;
      for (int i = 0; i < PAT_W && i < 4; i++) p[i] = base[i];
      return p;
   endfunction

   localparam logic [PAT_W-1:0] PAT_RST = pat_rst_val();

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_nxt;
   logic [PAT_W-1:0] pat;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill;
   logic [LEN_W-1:0] fill_nxt;
   logic [LEN_W-1:0] len;
   logic             accept;
   logic             hit;
   logic             len_bad;
   logic             z_q;
   logic             hist_unused;

   // The oldest history bit is shifted out before it can ever be compared.
   assign hist_unused = hist[PAT_W-1];

   always_comb begin
      accept   = x_valid & ~cfg_load;
      hist_nxt = {hist[PAT_W-2:0], x};
      fill_nxt = (fill == LEN_MAX) ? fill : fill + 1'b1;
      mask     = '0;
      for (int i = 0; i < PAT_W; i++) mask[i] = (LEN_W'(i) < len);
      hit      = accept & (fill_nxt >= len) & (((hist_nxt ^ pat) & mask) == '0);
      len_bad  = (cfg_len == '0) || (cfg_len > LEN_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist    <= '0;
         fill    <= '0;
         z_q     <= 1'b0;
         pat     <= PAT_RST;
         len     <= LEN_RST;
         cfg_err <= 1'b0;
      end else if (cfg_load) begin
         // x is ignored on a load edge; history restarts empty under the new config.
         hist    <= '0;
         fill    <= '0;
         z_q     <= 1'b0;
         pat     <= cfg_pattern;
         len     <= len_bad ? LEN_MAX : cfg_len;
         cfg_err <= cfg_err | len_bad;
      end else if (accept) begin
         hist <= hist_nxt;
         fill <= (hit && (OVERLAP == 0)) ? '0 : fill_nxt;
         z_q  <= hit;
      end else begin
         z_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (hit && (match_cnt != '1)) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end

   // Mealy output is gated by reset so it is guaranteed low while reset is held.
   assign z = (MEALY != 0) ? (hit & ~reset) : z_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

   localparam int K_Z   = 0;
   localparam int K_CNT = 1;
   localparam int K_ERR = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       x = 1'b1;
   logic       x_valid = 1'b1;
   logic       cfg_load = 1'b0;
   logic [3:0] cfg_pattern = 4'b0000;
   logic [2:0] cfg_len = 3'd0;
   logic       cnt_clr = 1'b0;

   logic [3:0] z_v;
   logic [3:0] err_v;
   logic [7:0] cnt0, cnt1, cnt2;
   logic [1:0] cnt3;

   always #5 clk = ~clk;

   // d0: overlap, Moore   d1: non-overlap, Moore   d2: overlap, Mealy   d3: overlap, Moore, CNT_W=2
   seq_detect_param #(.PAT_W(4), .OVERLAP(1), .MEALY(0), .CNT_W(8)) d0 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
      .z(z_v[0]), .match_cnt(cnt0), .cfg_err(err_v[0]));
   seq_detect_param #(.PAT_W(4), .OVERLAP(0), .MEALY(0), .CNT_W(8)) d1 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
      .z(z_v[1]), .match_cnt(cnt1), .cfg_err(err_v[1]));
   seq_detect_param #(.PAT_W(4), .OVERLAP(1), .MEALY(1), .CNT_W(8)) d2 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
      .z(z_v[2]), .match_cnt(cnt2), .cfg_err(err_v[2]));
   seq_detect_param #(.PAT_W(4), .OVERLAP(1), .MEALY(0), .CNT_W(2)) d3 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
      .z(z_v[3]), .match_cnt(cnt3), .cfg_err(err_v[3]));

   typedef struct {
      int    dut;
      int    kind;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   act;
   int   n_checks = 0;
   int   n_pass = 0;

   function automatic int actual(input int d, input int k);
      if (k == K_Z) return int'(z_v[d]);
      if (k == K_ERR) return int'(err_v[d]);
      case (d)
         0: return int'(cnt0);
         1: return int'(cnt1);
         2: return int'(cnt2);
         default: return int'(cnt3);
      endcase
   endfunction

   // Expected values are queued by the stimulus and consumed at the next falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         act = actual(e.dut, e.kind);
         n_checks++;
         if (act == e.val) n_pass++;
         else $display("FAIL %s (dut%0d): got %0d, expected %0d at %0t", e.name, e.dut, act, e.val, $time);
      end
   end

   task automatic chk(input int d, input int k, input int v, input string n);
      exp_t t;
      t.dut = d; t.kind = k; t.val = v; t.name = n;
      sb.push_back(t);
   endtask

   task automatic step(input logic xi, input logic vi, input logic ld = 1'b0, input logic clr = 1'b0);
      @(posedge clk);
      #1;
      x = xi; x_valid = vi; cfg_load = ld; cnt_clr = clr;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1; x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   bit sa[7]  = '{1, 0, 1, 1, 0, 1, 1};
   int za0[9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
   int za1[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
   int za2[9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
   bit sc[8]  = '{1, 0, 1, 1, 0, 1, 1, 0};
   bit se[4]  = '{0, 1, 0, 1};
   bit sf[4]  = '{1, 0, 1, 1};

   initial begin
      // Reset state, with a valid 1 on x to show the Mealy output stays low.
      chk(0, K_Z, 0, "rst_z");
      chk(0, K_CNT, 0, "rst_cnt");
      chk(0, K_ERR, 0, "rst_err");
      chk(2, K_Z, 0, "rst_mealy_z");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0; x_valid = 1'b0;

      // Consecutive stream 1011011.
      for (int k = 0; k < 9; k++) begin
         if (k < 7) step(sa[k], 1'b1);
         else step(1'b0, 1'b0);
         chk(0, K_Z, za0[k], "a_ovl_z");
         chk(1, K_Z, za1[k], "a_novl_z");
         chk(2, K_Z, za2[k], "a_mealy_z");
         if (k == 8) begin
            chk(0, K_CNT, 2, "a_ovl_cnt");
            chk(1, K_CNT, 1, "a_novl_cnt");
            chk(2, K_CNT, 2, "a_mealy_cnt");
            chk(3, K_CNT, 2, "a_cnt2_cnt");
         end
      end

      // Same stream with x_valid toggling; invalid cycles carry x=1.
      do_reset();
      for (int k = 0; k < 15; k++) begin
         if (k == 14) step(1'b0, 1'b0);
         else if (k % 2 == 0) step(sa[k/2], 1'b1);
         else step(1'b1, 1'b0);
         chk(2, K_Z, (k == 6 || k == 12) ? 1 : 0, "b_mealy_z");
         chk(0, K_Z, (k == 7 || k == 13) ? 1 : 0, "b_moore_z");
      end
      chk(2, K_CNT, 2, "b_mealy_cnt");

      // Load 110/L=3 (upper pattern bit set, must be ignored) after partial bits 1,0,1.
      do_reset();
      cfg_pattern = 4'b1110; cfg_len = 3'd3;
      for (int j = 0; j < 10; j++) begin
         if (j == 3) step(1'b1, 1'b1, 1'b1);
         else if (j < 8) step(sc[j], 1'b1);
         else step(1'b0, 1'b0);
         chk(2, K_Z, (j == 7) ? 1 : 0, "c_mealy_z");
         chk(0, K_Z, (j == 8) ? 1 : 0, "c_moore_z");
         chk(1, K_Z, (j == 8) ? 1 : 0, "c_novl_z");
      end
      chk(0, K_CNT, 1, "c_cnt");
      chk(0, K_ERR, 0, "c_err");

      // Saturation of a 2-bit counter, then clear coincident with a hit.
      do_reset();
      for (int j = 0; j < 21; j++) begin
         if (j < 4) step(sf[j], 1'b1);
         else if (j < 19) step(((j - 4) % 3) != 0, 1'b1, 1'b0, (j == 18));
         else step(1'b0, 1'b0);
         if (j == 7)  chk(3, K_CNT, 2, "d_cnt_2hits");
         if (j == 10) chk(3, K_CNT, 3, "d_cnt_3hits");
         if (j == 13) chk(3, K_CNT, 3, "d_sat_4hits");
         if (j == 16) begin
            chk(3, K_CNT, 3, "d_sat_5hits");
            chk(3, K_Z, 1, "d_z_5th");
            chk(0, K_CNT, 5, "d_wide_cnt");
         end
         if (j == 19) begin
            chk(3, K_CNT, 0, "d_clr_wins");
            chk(0, K_CNT, 0, "d_clr_wide");
            chk(3, K_Z, 1, "d_z_6th");
         end
         if (j == 20) chk(3, K_CNT, 0, "d_cnt_stays");
      end

      // Illegal cfg_len=0 -> clamp to 4, sticky error; then async reset mid-cycle.
      do_reset();
      cfg_pattern = 4'b0101; cfg_len = 3'd0;
      step(1'b1, 1'b1, 1'b1);
      chk(2, K_Z, 0, "e_load_no_z");
      for (int j = 0; j < 4; j++) begin
         step(se[j], 1'b1);
         chk(2, K_Z, (j == 3) ? 1 : 0, "e_clamp_z");
         if (j == 0) begin
            chk(0, K_ERR, 1, "e_err_set");
            chk(3, K_ERR, 1, "e_err_set3");
         end
      end
      step(1'b0, 1'b0);
      #1;
      reset = 1'b1;
      chk(0, K_Z, 0, "e_async_z");
      chk(0, K_CNT, 0, "e_async_cnt");
      chk(0, K_ERR, 0, "e_async_err");
      chk(2, K_CNT, 0, "e_async_cnt2");
      chk(2, K_Z, 0, "e_async_mealy");

      // After release the default pattern is back and a fresh L bits are needed.
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         step(sf[j], 1'b1);
         chk(2, K_Z, (j == 3) ? 1 : 0, "f_post_rst_z");
      end
      step(1'b0, 1'b0);
      chk(0, K_Z, 1, "f_moore_z");
      chk(0, K_ERR, 0, "f_err_clear");

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
